// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: address split, frame layout, FSM states.
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage: combinational read port, synchronous write port.
// Only the valid bits are reset; tag/data are don't-care until their frame is valid.
module icache_frame_array #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wen,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else if (wen) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wen) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a single outstanding fill.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  icache_state_t    state_q, state_d;
  logic [29:0]      miss_word_q, miss_word_d;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             fill_done;
  logic             miss_start;
  logic             unused_byte_off;

  assign req_idx         = imemaddr[IDX_W+1:2];
  assign req_tag         = imemaddr[31:IDX_W+2];
  assign unused_byte_off = ^imemaddr[1:0];

  icache_frame_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wen      (fill_done),
    .wr_idx   (miss_word_q[IDX_W-1:0]),
    .wr_tag   (miss_word_q[29:IDX_W]),
    .wr_data  (iload)
  );

  // Memory-side outputs depend only on FILL state and miss_word_q, never on imemaddr.
  always_comb begin
    state_d     = state_q;
    miss_word_d = miss_word_q;
    hit         = 1'b0;
    fill_done   = 1'b0;
    miss_start  = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    case (state_q)
      IDLE: begin
        hit  = imemREN && rd_valid && (rd_tag == req_tag);
        ihit = hit;
        if (hit) begin
          imemload = rd_data;
        end else if (imemREN) begin
          miss_start  = 1'b1;
          miss_word_d = imemaddr[31:2];
          state_d     = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {miss_word_q, 2'b00};
        if (!iwait) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_word_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_word_q <= miss_word_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-block instruction cache sitting between the pipelined datapath's fetch stage and the memory arbiter. It answers fetch requests combinationally on a hit. On a miss it runs a single outstanding memory read, fills the frame, then resumes hitting. The datapath stalls its PC and IF/ID latch on `ihit` low; this block never stalls on its own except through `ihit`.

## Interface
Parameters:
- `SETS`, 16, number of frames; power of two, ≥2; index width `IDX_W = $clog2(SETS)`.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  reset; asynchronous, active-high
- `imemREN`  in  1  datapath fetch request
- `imemaddr`  in  32  fetch byte address; bits [1:0] ignored
- `ihit`  out  1  fetch data valid this cycle
- `imemload`  out  32  instruction word; valid only when `ihit`=1, 0 otherwise
- `iREN`  out  1  memory read request
- `iaddr`  out  32  memory word address, bits [1:0] forced 0
- `iwait`  in  1  memory busy; read data valid in the cycle `iREN`=1 and `iwait`=0
- `iload`  in  32  memory read data
- `hit_count`  out  32  hit counter (see Configuration)
- `miss_count`  out  32  miss counter (see Configuration)

The clock is `CLK`. Reset is `RST`, asynchronous and active-high.

## Operation
- Address split: tag = [31:IDX_W+2], index = [IDX_W+1:2], byte offset = [1:0].
- Each frame holds `valid`, `tag`, `data`.
- States:
  - IDLE: compare the indexed frame.
    - Hit = `imemREN` & valid & tag match. A hit drives `ihit`=1 and `imemload`=data. No state change.
    - Miss with `imemREN`=1: latch `imemaddr` word address into `miss_addr`, then go to FILL.
    - `imemREN`=0: `ihit`=0, stay in IDLE.
  - FILL: `iREN`=1, `iaddr`=`miss_addr`, `ihit`=0.
    - On `iwait`=0: write frame[miss index] ← {1, miss tag, `iload`}, then go to IDLE.
    - On `iwait`=1: stay in FILL.
- A fill is never aborted:
  - Changes to `imemaddr` or `imemREN` during FILL are ignored.
  - The fill completes for `miss_addr`.
  - The IDLE lookup after the fill uses the current `imemaddr`. This covers branch redirects: the stale fill is harmless and the new address is looked up fresh.
- A fill always replaces the indexed frame; its previous contents are lost (conflict eviction).
- The cache is read-only. No self-modifying-code coherence is provided.

## Timing
- Reset values:
  - state = IDLE
  - all `valid` = 0
  - `miss_addr` = 0
  - `ihit` = 0, `imemload` = 0
  - `iREN` = 0, `iaddr` = 0
  - counters = 0
- Tag and data arrays need no reset.
- Reset asserted mid-FILL: `iREN` drops immediately (asynchronous). No frame is written.
- Hit latency: 0 cycles; `ihit` is combinational from `imemaddr` in IDLE.
- Miss timing, with N = cycles `iwait` stays high:
  - The miss is detected in cycle 0 and FILL is entered at edge 1.
  - `iREN` is high for N+1 cycles.
  - The fill is written at the edge ending the `iwait`=0 cycle.
  - The hit is returned in the next IDLE cycle.
  - Total miss-to-`ihit` = N+2 cycles.
- `iREN` and `iaddr` are Moore outputs of FILL; they are never combinational from `imemaddr`.
- Back-to-back misses: each costs a full FILL. There is no overlap.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on every IDLE cycle with a hit.
  - `miss_count` increments on each IDLE→FILL transition.
  - Both saturate at 32'hFFFF_FFFF and clear on `RST`.
- `ICACHE_STATS_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- `cpu_types_pkg` holds:
  - `icachef_t`, the packed address split {tag, idx, bytoff} for `SETS`=16.
  - `icache_frame_t`, the packed frame {valid, tag, data}.
  - The `icache_state_t` enum {IDLE, FILL}.
- Sub-module `icache_frame_array`:
  - `SETS`-entry storage with one combinational read port (index) and one synchronous write port (`wen`, index, frame).
  - Resets valid bits only.
- `icache` holds the FSM, `miss_addr`, compare logic and optional counters.

## Test plan
- Cold miss: after reset, `imemaddr`=0x0000_0040 and `imemREN`=1, with `iwait` high for 3 cycles and `iload`=0x2001_0005.
  - `iREN`=1 with `iaddr`=0x40 for 4 cycles.
  - `ihit`=1 with `imemload`=0x2001_0005 in cycle 5.
  - With stats enabled, `miss_count`=1.
- Warm hit: re-request 0x42 → `ihit`=1 the same cycle, `imemload`=0x2001_0005, `iREN` stays 0.
- Conflict: fill 0x40, then fetch 0x80 (same index 0, different tag).
  - The 0x80 fetch misses and fills.
  - Refetching 0x40 misses again.
- Redirect during FILL: miss on 0x100, then switch `imemaddr` to 0x200 while `iwait`=1.
  - `iaddr` stays 0x100.
  - After the fill, 0x200 misses and `iaddr`=0x200.
- Reset mid-FILL: assert `RST` while `iREN`=1.
  - `iREN` goes to 0 in the same cycle.
  - After release, the prior address misses (valid was cleared).
- `imemREN`=0 on a valid address → `ihit`=0 and `imemload`=0, no state change, `hit_count` unchanged.
